dispatch_window: RTL and testbench
==================================

# dispatch_window

Holding buffer and sequencer that sits between instruction fetch and the type sorter. It keeps up to FETCH_WIDTH decoded 24-bit instructions in program order and presents them to the sorter as a window. Each cycle it retires the slots the sorter reports as used, compacts the survivors toward slot 0, and refills from fetch. When a terminating (control-flow) instruction issues, it discards the wrong-path entries younger than it and stalls fetch until a redirect arrives.

## Interface
- FETCH_WIDTH, 4, window slots (≥2)
- INSTR_W, 24, instruction width; opcode is bits [INSTR_W-1:INSTR_W-4]

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- fetch_instr  in  INSTR_W  instruction from fetch
- fetch_valid  in  1  fetch_instr is valid
- fetch_ready  out  1  window accepts one instruction this cycle
- win_instr  out  FETCH_WIDTH*INSTR_W  slot k occupies bits [k*INSTR_W +: INSTR_W]; slot 0 is oldest
- win_valid  out  FETCH_WIDTH  slot valid mask; always contiguous from bit 0
- win_used  in  FETCH_WIDTH  sorter consumed slot k this cycle; ignored where win_valid[k]=0
- redirect_valid  in  1  fetch redirected after a terminating instruction
- flush  in  1  discard the whole window (exception or replay)
- waiting  out  1  state is WAIT_REDIRECT

## Operation
- State: count (0..FETCH_WIDTH), slot registers, and FSM {RUN, WAIT_REDIRECT}.
- fetch_ready = ~rst & (state==RUN) & (count < FETCH_WIDTH), using the registered count.
- Retire: eff_used = win_used & win_valid. Survivors are valid slots with eff_used=0. They shift down to slots 0.. while keeping relative order. Non-contiguous used masks are legal.
- Term detection: a slot is a term if it is valid and opcode[3:1]==3'b111. t = lowest-index term slot.
- If a term exists and eff_used[t]=1:
  - discard all slots with index > t, whether or not they were used;
  - older unused slots survive;
  - state goes to WAIT_REDIRECT.
- Append: if fetch_valid & fetch_ready, the instruction goes into slot (survivor count). A fetch accepted in the same cycle as a term issue is discarded.
- WAIT_REDIRECT: fetch_ready=0. Surviving entries keep issuing and retiring normally. redirect_valid moves the FSM to RUN.
- redirect_valid in RUN is ignored.
- A term issue and redirect_valid in the same cycle: discard as above, FSM stays in RUN.
- flush:
  - next cycle win_valid=0, count=0, FSM=RUN;
  - overrides used, fetch (an accepted instruction is dropped), term and redirect.
- Invalid slots hold don't-care data. The bench must only check win_instr under win_valid.
- count' = survivors + appended; never exceeds FETCH_WIDTH.

## Timing
- Reset values: win_valid=0, count=0, FSM=RUN, waiting=0, fetch_ready=0 while rst=1 and 1 in the first cycle after.
- Reset mid-WAIT_REDIRECT returns the FSM to RUN and empties the window.
- Fill latency: an instruction accepted at edge N is visible in win_valid/win_instr after edge N. That is 1 cycle, with no bypass from fetch to window.
- Retire latency: a slot used in cycle N is gone after edge N.
- Full window: fetch_ready=0 even if the same cycle retires slots. Refill resumes the cycle after retire.
- win_valid, win_instr and waiting are registered outputs. fetch_ready is combinational from registers and rst only, with no path from fetch_valid or win_used.
- Throughput: at most one fetch per cycle; up to FETCH_WIDTH retires per cycle.

## Configuration
- DISPATCH_WINDOW_STATS_EN defined:
  - adds outputs stat_issued [31:0] and stat_stall [31:0];
  - stat_issued increments by popcount(eff_used) each cycle, excluding flush cycles;
  - stat_stall increments each cycle with state==WAIT_REDIRECT or count==FETCH_WIDTH;
  - both reset to 0 on rst and wrap modulo 2^32.
- Not defined: these ports and counters are absent, and all other behaviour is identical.

## Test plan
- Fill: reset, then drive 0x000001..0x000004 with fetch_valid=1 and win_used=0. Expect win_valid 0001→0011→0111→1111, slot order 1,2,3,4, and fetch_ready=0 once full.
- Out-of-order retire: full window [1,2,3,4], win_used=0101, fetch 0x000005 offered. Expect fetch_ready=0 that cycle and next win_valid=0011 with slots [2,4]. The cycle after, 0x000005 is accepted and the window is [2,4,5].
- Term issue: window [0x100000, 0xE00000, 0x000007, 0x000008], win_used=0010. Expect next win_valid=0001 holding slot0=0x100000, waiting=1 and fetch_ready=0. redirect_valid=1 for one cycle gives waiting=0 and fetch_ready=1 on the next cycle.
- Term issued together with redirect_valid and an accepted fetch: the fetched instruction is dropped and waiting stays 0.
- Flush: flush=1 together with fetch_valid=1, win_used=1111 and redirect_valid=1 gives next win_valid=0 and count=0. After reset during WAIT_REDIRECT, waiting=0.
- STATS_EN: three retires in cycle 1 and one in cycle 2, then 5 cycles in WAIT_REDIRECT. Expect stat_issued=4 and stat_stall=5.

Source files
------------

// File: rtl/dispatch_window_if.sv
// dispatch_window_if: fetch-side and sorter-side handshake bundle for the dispatch window.
interface dispatch_window_if #(
    parameter int FETCH_WIDTH = 4,
    parameter int INSTR_W = 24
);
    logic [INSTR_W-1:0] fetch_instr;
    logic fetch_valid;
    logic fetch_ready;
    logic [FETCH_WIDTH*INSTR_W-1:0] win_instr;
    logic [FETCH_WIDTH-1:0] win_valid;
    logic [FETCH_WIDTH-1:0] win_used;
    logic redirect_valid;
    logic flush;
    logic waiting;
    modport master (
        output fetch_instr, fetch_valid, win_used, redirect_valid, flush,
        input fetch_ready, win_instr, win_valid, waiting
    );
    modport slave (
        input fetch_instr, fetch_valid, win_used, redirect_valid, flush,
        output fetch_ready, win_instr, win_valid, waiting
    );
endinterface

// File: rtl/dispatch_window.sv
// dispatch_window: in-order instruction window with compaction, term squash and redirect wait.
// Define DISPATCH_WINDOW_STATS_EN to add the stat_issued/stat_stall counters.
module dispatch_window #(
    parameter int FETCH_WIDTH = 4,
    parameter int INSTR_W = 24
) (
    input logic clk,
    input logic rst,
    dispatch_window_if.slave bus
`ifdef DISPATCH_WINDOW_STATS_EN
    ,
    output logic [31:0] stat_issued,
    output logic [31:0] stat_stall
`endif
);
    localparam int CW = $clog2(FETCH_WIDTH + 1);
    typedef enum logic {RUN, WAIT_REDIRECT} state_t;
    state_t state, state_nx;
    logic [CW-1:0] count, count_nx, surv;
    logic [FETCH_WIDTH-1:0] valid, valid_nx, eff_used, keep, is_term;
    logic [INSTR_W-1:0] slots [FETCH_WIDTH];
    logic [INSTR_W-1:0] slots_nx [FETCH_WIDTH];
    logic found, cut, append;

    assign bus.fetch_ready = ~rst & (state == RUN) & (count < CW'(FETCH_WIDTH));
    assign bus.win_valid = valid;
    assign bus.waiting = (state == WAIT_REDIRECT);

    for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_win
        assign bus.win_instr[k*INSTR_W +: INSTR_W] = slots[k];
    end

    // cut goes high once the oldest term has issued; everything younger is squashed
    always_comb begin
        eff_used = bus.win_used & valid;
        found = 1'b0;
        cut = 1'b0;
        surv = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            slots_nx[k] = slots[k];
            is_term[k] = valid[k] & (slots[k][INSTR_W-1 -: 3] == 3'b111);
        end
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            keep[k] = valid[k] & ~eff_used[k] & ~cut;
            for (int j = 0; j < FETCH_WIDTH; j++)
                if (keep[k] && CW'(j) == surv) slots_nx[j] = slots[k];
            surv = keep[k] ? surv + CW'(1) : surv;
            if (is_term[k] && !found) begin
                found = 1'b1;
                cut = eff_used[k];
            end
        end
        append = bus.fetch_valid & bus.fetch_ready & ~cut;
        for (int j = 0; j < FETCH_WIDTH; j++)
            if (append && CW'(j) == surv) slots_nx[j] = bus.fetch_instr;
        count_nx = bus.flush ? '0 : surv + CW'(append);
        for (int k = 0; k < FETCH_WIDTH; k++)
            valid_nx[k] = CW'(k) < count_nx;
        state_nx = bus.flush ? RUN :
                   cut ? (bus.redirect_valid ? RUN : WAIT_REDIRECT) :
                   (state == WAIT_REDIRECT && bus.redirect_valid) ? RUN : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            count <= '0;
            valid <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            valid <= valid_nx;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_WIDTH; k++)
            slots[k] <= slots_nx[k];
    end

`ifdef DISPATCH_WINDOW_STATS_EN
    logic [31:0] issued_inc;

    always_comb begin
        issued_inc = '0;
        for (int k = 0; k < FETCH_WIDTH; k++)
            issued_inc = issued_inc + 32'(eff_used[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued <= '0;
            stat_stall <= '0;
        end else begin
            stat_issued <= stat_issued + (bus.flush ? 32'd0 : issued_inc);
            stat_stall <= stat_stall + 32'((state == WAIT_REDIRECT) || (count == CW'(FETCH_WIDTH)));
        end
    end
`endif
endmodule

// File: tb/tb_dispatch_window.sv
// tb_dispatch_window: directed scenario bench for dispatch_window.
module tb_dispatch_window;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dispatch_window_if #(.FETCH_WIDTH(4), .INSTR_W(24)) bus ();
`ifdef DISPATCH_WINDOW_STATS_EN
    logic [31:0] stat_issued, stat_stall;
    dispatch_window #(.FETCH_WIDTH(4), .INSTR_W(24)) dut (
        .clk(clk), .rst(rst), .bus(bus), .stat_issued(stat_issued), .stat_stall(stat_stall));
`else
    dispatch_window #(.FETCH_WIDTH(4), .INSTR_W(24)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    function automatic logic [23:0] slot(input int k);
        return bus.win_instr[k*24 +: 24];
    endfunction

    task automatic idle();
        bus.fetch_valid = 1'b0;
        bus.fetch_instr = '0;
        bus.win_used = '0;
        bus.redirect_valid = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic push(input logic [23:0] v);
        bus.fetch_instr = v;
        bus.fetch_valid = 1'b1;
        total++;
        if (bus.fetch_ready !== 1'b1) begin
            bad++;
            $display("FAIL push_ready got=%b want=1", bus.fetch_ready);
        end
        @(negedge clk);
        bus.fetch_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        total += 3;
        if (bus.win_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b want=0000", bus.win_valid); end
        if (bus.waiting !== 1'b0) begin bad++; $display("FAIL reset_waiting got=%b want=0", bus.waiting); end
        if (bus.fetch_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst got=%b want=0", bus.fetch_ready); end
        rst = 1'b0;
        #1;
        total++;
        if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b want=1", bus.fetch_ready); end
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic [3:0] exp_valid;
        for (int i = 1; i <= 4; i++) begin
            push(24'(i));
            exp_valid = 4'((1 << i) - 1);
            total += 2;
            if (bus.win_valid !== exp_valid) begin bad++; $display("FAIL fill_valid%0d got=%b want=%b", i, bus.win_valid, exp_valid); end
            if (slot(i - 1) !== 24'(i)) begin bad++; $display("FAIL fill_slot%0d got=%h want=%h", i - 1, slot(i - 1), 24'(i)); end
        end
        bus.fetch_instr = 24'h000005;
        bus.fetch_valid = 1'b1;
        #1;
        total++;
        if (bus.fetch_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b want=0", bus.fetch_ready); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (slot(i) !== 24'(i + 1)) begin bad++; $display("FAIL fill_order%0d got=%h want=%h", i, slot(i), 24'(i + 1)); end
        end
    endtask

    task automatic test_ooo_retire();
        bus.win_used = 4'b0101;
        @(negedge clk);
        bus.win_used = 4'b0000;
        total += 4;
        if (bus.win_valid !== 4'b0011) begin bad++; $display("FAIL ooo_valid got=%b want=0011", bus.win_valid); end
        if (slot(0) !== 24'h2) begin bad++; $display("FAIL ooo_slot0 got=%h want=000002", slot(0)); end
        if (slot(1) !== 24'h4) begin bad++; $display("FAIL ooo_slot1 got=%h want=000004", slot(1)); end
        if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL ooo_ready got=%b want=1", bus.fetch_ready); end
        @(negedge clk);
        bus.fetch_valid = 1'b0;
        total += 2;
        if (bus.win_valid !== 4'b0111) begin bad++; $display("FAIL ooo_refill_valid got=%b want=0111", bus.win_valid); end
        if (slot(2) !== 24'h5) begin bad++; $display("FAIL ooo_refill_slot2 got=%h want=000005", slot(2)); end
        bus.win_used = 4'b1111;
        @(negedge clk);
        bus.win_used = 4'b0000;
        total++;
        if (bus.win_valid !== 4'b0000) begin bad++; $display("FAIL retire_all got=%b want=0000", bus.win_valid); end
    endtask

    task automatic test_term();
        push(24'h100000);
        push(24'hE00000);
        push(24'h000007);
        push(24'h000008);
        bus.win_used = 4'b0010;
        @(negedge clk);
        bus.win_used = 4'b0000;
        total += 4;
        if (bus.win_valid !== 4'b0001) begin bad++; $display("FAIL term_valid got=%b want=0001", bus.win_valid); end
        if (slot(0) !== 24'h100000) begin bad++; $display("FAIL term_slot0 got=%h want=100000", slot(0)); end
        if (bus.waiting !== 1'b1) begin bad++; $display("FAIL term_waiting got=%b want=1", bus.waiting); end
        if (bus.fetch_ready !== 1'b0) begin bad++; $display("FAIL term_ready got=%b want=0", bus.fetch_ready); end
        bus.win_used = 4'b0001;
        @(negedge clk);
        bus.win_used = 4'b0000;
        total += 3;
        if (bus.win_valid !== 4'b0000) begin bad++; $display("FAIL wait_retire_valid got=%b want=0000", bus.win_valid); end
        if (bus.waiting !== 1'b1) begin bad++; $display("FAIL wait_hold got=%b want=1", bus.waiting); end
        if (bus.fetch_ready !== 1'b0) begin bad++; $display("FAIL wait_ready got=%b want=0", bus.fetch_ready); end
        bus.redirect_valid = 1'b1;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        total += 2;
        if (bus.waiting !== 1'b0) begin bad++; $display("FAIL redirect_waiting got=%b want=0", bus.waiting); end
        if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL redirect_ready got=%b want=1", bus.fetch_ready); end
        bus.redirect_valid = 1'b1;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        total++;
        if (bus.waiting !== 1'b0) begin bad++; $display("FAIL redirect_in_run got=%b want=0", bus.waiting); end
    endtask

    task automatic test_term_redirect();
        push(24'h000011);
        push(24'hF00022);
        bus.win_used = 4'b0010;
        bus.redirect_valid = 1'b1;
        bus.fetch_instr = 24'h000033;
        bus.fetch_valid = 1'b1;
        #1;
        total++;
        if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL tr_ready_pre got=%b want=1", bus.fetch_ready); end
        @(negedge clk);
        idle();
        total += 3;
        if (bus.win_valid !== 4'b0001) begin bad++; $display("FAIL tr_valid got=%b want=0001", bus.win_valid); end
        if (slot(0) !== 24'h000011) begin bad++; $display("FAIL tr_slot0 got=%h want=000011", slot(0)); end
        if (bus.waiting !== 1'b0) begin bad++; $display("FAIL tr_waiting got=%b want=0", bus.waiting); end
    endtask

    task automatic test_flush();
        push(24'h000044);
        total++;
        if (bus.win_valid !== 4'b0011) begin bad++; $display("FAIL flush_pre_valid got=%b want=0011", bus.win_valid); end
        bus.flush = 1'b1;
        bus.fetch_instr = 24'h000055;
        bus.fetch_valid = 1'b1;
        bus.win_used = 4'b1111;
        bus.redirect_valid = 1'b1;
        @(negedge clk);
        idle();
        total += 3;
        if (bus.win_valid !== 4'b0000) begin bad++; $display("FAIL flush_valid got=%b want=0000", bus.win_valid); end
        if (bus.waiting !== 1'b0) begin bad++; $display("FAIL flush_waiting got=%b want=0", bus.waiting); end
        if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", bus.fetch_ready); end
        @(negedge clk);
        total++;
        if (bus.win_valid !== 4'b0000) begin bad++; $display("FAIL flush_settle got=%b want=0000", bus.win_valid); end
    endtask

    task automatic test_reset_wait();
        push(24'hE00000);
        bus.win_used = 4'b0001;
        @(negedge clk);
        bus.win_used = 4'b0000;
        total++;
        if (bus.waiting !== 1'b1) begin bad++; $display("FAIL rw_enter got=%b want=1", bus.waiting); end
        rst = 1'b1;
        @(negedge clk);
        total += 3;
        if (bus.waiting !== 1'b0) begin bad++; $display("FAIL rw_waiting got=%b want=0", bus.waiting); end
        if (bus.win_valid !== 4'b0000) begin bad++; $display("FAIL rw_valid got=%b want=0000", bus.win_valid); end
        if (bus.fetch_ready !== 1'b0) begin bad++; $display("FAIL rw_ready_in_rst got=%b want=0", bus.fetch_ready); end
        rst = 1'b0;
        #1;
        total++;
        if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL rw_ready_after got=%b want=1", bus.fetch_ready); end
        @(negedge clk);
    endtask

`ifdef DISPATCH_WINDOW_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total += 2;
        if (stat_issued !== 32'd0) begin bad++; $display("FAIL stats_rst_issued got=%0d want=0", stat_issued); end
        if (stat_stall !== 32'd0) begin bad++; $display("FAIL stats_rst_stall got=%0d want=0", stat_stall); end
        push(24'h000001);
        push(24'h000002);
        push(24'h000003);
        bus.win_used = 4'b0111;
        bus.fetch_instr = 24'hE00004;
        bus.fetch_valid = 1'b1;
        @(negedge clk);
        bus.fetch_valid = 1'b0;
        bus.win_used = 4'b0001;
        @(negedge clk);
        bus.win_used = 4'b0000;
        repeat (5) @(negedge clk);
        total += 2;
        if (stat_issued !== 32'd4) begin bad++; $display("FAIL stats_issued got=%0d want=4", stat_issued); end
        if (stat_stall !== 32'd5) begin bad++; $display("FAIL stats_stall got=%0d want=5", stat_stall); end
        bus.redirect_valid = 1'b1;
        @(negedge clk);
        idle();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        test_reset();
        test_fill();
        test_ooo_retire();
        test_term();
        test_term_redirect();
        test_flush();
        test_reset_wait();
`ifdef DISPATCH_WINDOW_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
